nrzi_encoder: RTL and testbench

NRZI_ENCODER -- requirements
Module: nrzi_encoder

---
 rtl/nrzi_encoder.sv | 131 +++++++++++++
 tb/tb_nrzi_encoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/nrzi_encoder.sv
// NRZI line encoder with bit stuffing and SE0,SE0,J end-of-packet; the line changes one edge after a bit is accepted.
// din_ready drops for the single stuff cycle and for the whole EOP sequence; all outputs except din_ready are flops.
module nrzi_encoder (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_valid,
  output logic din_ready,
  input  logic eop_req,
  output logic DPout,
  output logic DMout,
  output logic oe,
  output logic eop_done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    EOP1 = 3'd2,
    EOP2 = 3'd3,
    EOPJ = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       dp_q, dp_d;
  logic       dm_q, dm_d;
  logic       oe_q, oe_d;
  logic       done_q, done_d;
  logic [2:0] ones_q, ones_d;
  logic       stuff;

  // Six ones in a row force one toggled bit before any further data or EOP.
  assign stuff     = (state_q == DATA) && (ones_q == 3'd6);
  assign din_ready = (state_q == IDLE) || ((state_q == DATA) && (ones_q < 3'd6));

  always_comb begin
    state_d = state_q;
    dp_d    = dp_q;
    dm_d    = dm_q;
    oe_d    = oe_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        dp_d   = 1'b1;
        dm_d   = 1'b0;
        oe_d   = 1'b0;
        ones_d = 3'd0;
        if (din_valid) begin
          state_d = DATA;
          oe_d    = 1'b1;
          if (din) begin
            ones_d = 3'd1;
          end else begin
            dp_d = 1'b0;
            dm_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (stuff) begin
          dp_d   = ~dp_q;
          dm_d   = ~dm_q;
          ones_d = 3'd0;
        end else if (din_valid) begin
          if (din) begin
            ones_d = ones_q + 3'd1;
          end else begin
            dp_d   = ~dp_q;
            dm_d   = ~dm_q;
            ones_d = 3'd0;
          end
        end else if (eop_req) begin
          state_d = EOP1;
          dp_d    = 1'b0;
          dm_d    = 1'b0;
          ones_d  = 3'd0;
        end
      end
      EOP1: begin
        state_d = EOP2;
        dp_d    = 1'b0;
        dm_d    = 1'b0;
      end
      EOP2: begin
        state_d = EOPJ;
        dp_d    = 1'b1;
        dm_d    = 1'b0;
        oe_d    = 1'b1;
      end
      EOPJ: begin
        state_d = IDLE;
        dp_d    = 1'b1;
        dm_d    = 1'b0;
        oe_d    = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        dp_d    = 1'b1;
        dm_d    = 1'b0;
        oe_d    = 1'b0;
        ones_d  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      ones_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      ones_q  <= ones_d;
    end
  end

  assign DPout    = dp_q;
  assign DMout    = dm_q;
  assign oe       = oe_q;
  assign eop_done = done_q;

endmodule

// File: tb/tb_nrzi_encoder.sv
// Directed bench for nrzi_encoder: hand-computed line symbols after each edge plus a running line/pulse monitor.
module tb_nrzi_encoder;

  logic clk;
  logic rst;
  logic din;
  logic din_valid;
  logic din_ready;
  logic eop_req;
  logic DPout;
  logic DMout;
  logic oe;
  logic eop_done;

  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  logic prev_done = 1'b0;

  nrzi_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .eop_req   (eop_req),
    .DPout     (DPout),
    .DMout     (DMout),
    .oe        (oe),
    .eop_done  (eop_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input logic [1:0] exp);
    logic [1:0] obs;
    obs = {DPout, DMout};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s line observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then look at the outputs just after the edge.
  task automatic cyc(input logic v, input logic d, input logic e);
    din_valid = v;
    din       = d;
    eop_req   = e;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk_bit("no_se1", DPout & DMout, 1'b0);
      chk_bit("done_single", eop_done & prev_done, 1'b0);
      prev_done = eop_done;
    end
  end

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; eop_req = 1'b0;
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    rst = 1'b0;
    mon_en = 1'b1;
    chk_line("rst_line", J);
    chk_bit("rst_oe", oe, 1'b0);
    chk_bit("rst_done", eop_done, 1'b0);
    chk_bit("rst_ready", din_ready, 1'b1);

    // Bits 0,1,1,0 from idle
    cyc(1, 0, 0); chk_line("t1_b0", K); chk_bit("t1_oe", oe, 1'b1);
    cyc(1, 1, 0); chk_line("t1_b1", K);
    cyc(1, 1, 0); chk_line("t1_b2", K);
    cyc(1, 0, 0); chk_line("t1_b3", J);
    cyc(0, 0, 1); chk_line("t1_eop1", SE0); chk_bit("t1_eop1_rdy", din_ready, 1'b0);
    cyc(0, 0, 0); chk_line("t1_eop2", SE0); chk_bit("t1_eop2_oe", oe, 1'b1);
    cyc(0, 0, 0); chk_line("t1_eopj", J); chk_bit("t1_eopj_oe", oe, 1'b1);
    chk_bit("t1_eopj_done", eop_done, 1'b0);
    cyc(0, 0, 0); chk_bit("t1_done", eop_done, 1'b1); chk_bit("t1_idle_oe", oe, 1'b0);
    chk_bit("t1_idle_rdy", din_ready, 1'b1);
    cyc(0, 0, 0); chk_bit("t1_done_drop", eop_done, 1'b0);

    // eop_req in IDLE is ignored
    cyc(0, 0, 1); chk_line("idle_eop_line", J); chk_bit("idle_eop_oe", oe, 1'b0);
    chk_bit("idle_eop_rdy", din_ready, 1'b1);

    // 0 then seven 1s: stuff after the sixth
    cyc(1, 0, 0); chk_line("t2_k", K);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 0); chk_line("t2_ones", K);
    end
    chk_bit("t2_stuff_rdy", din_ready, 1'b0);
    cyc(1, 1, 0); chk_line("t2_stuff", J); chk_bit("t2_rdy_back", din_ready, 1'b1);
    cyc(1, 1, 0); chk_line("t2_seventh", J);
    cyc(0, 0, 1); chk_line("t2_eop1", SE0);
    cyc(0, 0, 0); chk_line("t2_eop2", SE0);
    cyc(0, 0, 0); chk_line("t2_eopj", J);
    cyc(0, 0, 0); chk_bit("t2_done", eop_done, 1'b1);

    // Back-to-back packet: 0 then six 1s, then eop_req with stuff pending
    cyc(1, 0, 0); chk_line("t3_k", K); chk_bit("t3_done_drop", eop_done, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1, 0); chk_line("t3_ones", K);
    end
    cyc(0, 0, 1); chk_line("t3_stuff", J); chk_bit("t3_stuff_oe", oe, 1'b1);
    chk_bit("t3_rdy", din_ready, 1'b1);
    cyc(0, 0, 1); chk_line("t3_eop1", SE0);
    cyc(0, 0, 0); chk_line("t3_eop2", SE0);
    cyc(0, 0, 0); chk_line("t3_eopj", J); chk_bit("t3_eopj_oe", oe, 1'b1);
    cyc(0, 0, 0); chk_line("t3_idle", J); chk_bit("t3_done", eop_done, 1'b1);
    chk_bit("t3_oe", oe, 1'b0);
    cyc(0, 0, 0); chk_bit("t3_done_drop", eop_done, 1'b0);

    // Five 1s, three idle cycles, one more 1 -> stuff
    cyc(1, 1, 0); chk_line("t4_first1", J); chk_bit("t4_oe", oe, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0); chk_line("t4_ones", J);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0); chk_line("t4_gap", J); chk_bit("t4_gap_rdy", din_ready, 1'b1);
    end
    cyc(1, 1, 0); chk_line("t4_sixth", J); chk_bit("t4_stuff_rdy", din_ready, 1'b0);
    cyc(1, 0, 0); chk_line("t4_stuff", K); chk_bit("t4_rdy_back", din_ready, 1'b1);
    cyc(1, 0, 0); chk_line("t4_zero", J);
    cyc(0, 0, 1); chk_line("t4_eop1", SE0);
    cyc(0, 0, 0); chk_line("t4_eop2", SE0);
    cyc(0, 0, 0); chk_line("t4_eopj", J);
    cyc(0, 0, 0); chk_bit("t4_done", eop_done, 1'b1);

    // Reset during EOP2
    cyc(1, 0, 0); chk_line("t5_k", K);
    cyc(0, 0, 1); chk_line("t5_eop1", SE0);
    cyc(0, 0, 0); chk_line("t5_eop2", SE0);
    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
    chk_line("t5_rst_line", J); chk_bit("t5_rst_oe", oe, 1'b0);
    chk_bit("t5_rst_done", eop_done, 1'b0); chk_bit("t5_rst_rdy", din_ready, 1'b1);
    cyc(0, 0, 0); chk_bit("t5_no_done", eop_done, 1'b0); chk_line("t5_idle", J);

    // Reset mid-data, then a fresh packet starts from J
    cyc(1, 0, 0); chk_line("t6_k", K);
    rst = 1'b1;
    cyc(1, 0, 0);
    rst = 1'b0;
    chk_line("t6_rst_line", J); chk_bit("t6_rst_oe", oe, 1'b0);
    cyc(1, 0, 0); chk_line("t6_restart", K); chk_bit("t6_oe", oe, 1'b1);
    cyc(1, 1, 0); chk_line("t6_hold", K);

    cyc(0, 0, 0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
